timestamp_packetizer: RTL and testbench

Reads the free-running 24-bit mission timestamp, which advances once per 10 Hz tick, into the system clock domain. It accepts each new value only after it has stayed stable, then frames it as a 5-byte telemetry packet. The packet goes out through a byte-wide valid/ready stream toward the downlink UART transmitter. The block is the consumer end of the timestamp bus; the ground segment uses its packets to time-tag NeoPod data.

---
 rtl/timestamp_packetizer.sv | 136 +++++++++++++
 tb/tb_timestamp_packetizer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/timestamp_packetizer.sv
// Captures the asynchronous 24-bit mission timestamp, accepts it once stable,
// and frames each new value as a 5-byte packet on a byte-wide valid/ready stream.
module timestamp_packetizer #(
  parameter int          STABLE_CYCLES = 4,
  parameter logic [7:0]  HEADER        = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] timestamp,
  input  logic        enable,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        frame_busy,
  output logic [23:0] ts_latched,
  output logic        overrun,
  output logic [2:0]  dbg_state
);

  // Stream handshake: a byte transfers on every rising edge where tx_valid && tx_ready;
  // while tx_valid is high and tx_ready low, tx_data and tx_valid hold steady.

  localparam logic [3:0] STAB_MAX = 4'(STABLE_CYCLES);

  typedef enum logic [2:0] {IDLE, HDR, B2, B1, B0, CSUM} state_t;

  state_t      state, state_next;
  logic [23:0] ts_s1, ts_s2;
  logic [3:0]  stab_cnt;
  logic        latch_valid;
  logic [23:0] frame_ts, frame_ts_next;
  logic [23:0] pend_ts, pend_ts_next;
  logic        pend_valid, pend_valid_next;
  logic        overrun_next;
  logic        qualify, queue_new, fire, csum_fire;

  assign qualify   = (stab_cnt == STAB_MAX) && ((ts_s2 != ts_latched) || !latch_valid);
  assign queue_new = qualify && enable;
  assign fire      = tx_valid && tx_ready;
  assign csum_fire = (state == CSUM) && fire;

  // Two-flop capture plus stability counter; the bus is sampled as a whole word.
  always_ff @(posedge clk) begin
    if (reset) begin
      ts_s1       <= '0;
      ts_s2       <= '0;
      stab_cnt    <= '0;
      ts_latched  <= '0;
      latch_valid <= 1'b0;
    end else begin
      ts_s1 <= timestamp;
      ts_s2 <= ts_s1;
      if (ts_s1 != ts_s2)
        stab_cnt <= '0;
      else if (stab_cnt != STAB_MAX)
        stab_cnt <= stab_cnt + 4'd1;
      if (qualify) begin
        ts_latched  <= ts_s2;
        latch_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      frame_ts   <= '0;
      pend_ts    <= '0;
      pend_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_next;
      frame_ts   <= frame_ts_next;
      pend_ts    <= pend_ts_next;
      pend_valid <= pend_valid_next;
      overrun    <= overrun_next;
    end
  end

  always_comb begin
    state_next      = state;
    frame_ts_next   = frame_ts;
    pend_ts_next    = pend_ts;
    pend_valid_next = pend_valid;
    overrun_next    = overrun;
    case (state)
      IDLE: if (queue_new) begin
        frame_ts_next = ts_s2;
        state_next    = HDR;
      end
      HDR:  if (fire) state_next = B2;
      B2:   if (fire) state_next = B1;
      B1:   if (fire) state_next = B0;
      B0:   if (fire) state_next = CSUM;
      CSUM: if (fire) begin
        // A value arriving on the closing edge lands in the pending slot and is
        // consumed at once, overwriting anything that was already waiting.
        if (queue_new) begin
          frame_ts_next   = ts_s2;
          pend_valid_next = 1'b0;
          overrun_next    = overrun | pend_valid;
          state_next      = HDR;
        end else if (pend_valid) begin
          frame_ts_next   = pend_ts;
          pend_valid_next = 1'b0;
          state_next      = HDR;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (queue_new && (state != IDLE) && !csum_fire) begin
      pend_ts_next    = ts_s2;
      pend_valid_next = 1'b1;
      overrun_next    = overrun | pend_valid;
    end
  end

  always_comb begin
    tx_data = 8'h00;
    case (state)
      HDR:     tx_data = HEADER;
      B2:      tx_data = frame_ts[23:16];
      B1:      tx_data = frame_ts[15:8];
      B0:      tx_data = frame_ts[7:0];
      CSUM:    tx_data = HEADER ^ frame_ts[23:16] ^ frame_ts[15:8] ^ frame_ts[7:0];
      default: tx_data = 8'h00;
    endcase
  end

  assign tx_valid   = (state != IDLE);
  assign frame_busy = (state != IDLE);
  assign dbg_state  = state;

endmodule

// File: tb/tb_timestamp_packetizer.sv
// Bench for timestamp_packetizer: expected packet bytes are queued when a timestamp
// is driven and compared as the stream hands them over.
module tb_timestamp_packetizer;

  localparam int         STABLE = 4;
  localparam logic [7:0] HDR_B  = 8'hA5;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_B2   = 3'd2;
  localparam logic [2:0] ST_B1   = 3'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] timestamp;
  logic        enable;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        frame_busy;
  logic [23:0] ts_latched;
  logic        overrun;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  timestamp_packetizer #(.STABLE_CYCLES(STABLE), .HEADER(HDR_B)) dut (
    .clk(clk), .reset(reset), .timestamp(timestamp), .enable(enable),
    .tx_ready(tx_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .frame_busy(frame_busy), .ts_latched(ts_latched), .overrun(overrun),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [23:0] ts);
    logic [7:0] b2, b1, b0;
    b2 = ts[23:16];
    b1 = ts[15:8];
    b0 = ts[7:0];
    exp_q.push_back(HDR_B);
    exp_q.push_back(b2);
    exp_q.push_back(b1);
    exp_q.push_back(b0);
    exp_q.push_back(HDR_B ^ b2 ^ b1 ^ b0);
  endtask

  // Called just after a rising edge: lat counts falling edges until tx_valid,
  // len counts falling edges with frame_busy high afterwards.
  task automatic wait_frame(input int budget, output int lat, output int len);
    lat = 0;
    len = 0;
    @(negedge clk);
    while (!tx_valid && lat < budget) begin
      lat++;
      @(negedge clk);
    end
    check("frame_start", {31'd0, tx_valid}, 32'd1);
    while (frame_busy && len < budget) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || frame_busy) && k < budget) begin
      k++;
      @(negedge clk);
    end
    check("drain", exp_q.size(), 0);
    step(1);
  endtask

  task automatic wait_state(input logic [2:0] st, input string tag);
    int k;
    k = 0;
    step(1);
    while (dbg_state != st && k < 40) begin
      k++;
      step(1);
    end
    check(tag, {29'd0, dbg_state}, {29'd0, st});
  endtask

  // scoreboard: bytes are taken on the next rising edge when valid && ready
  always @(negedge clk) begin
    if (prev_stall) begin
      check("stall_valid", {31'd0, tx_valid}, 32'd1);
      check("stall_data", {24'd0, tx_data}, {24'd0, prev_data});
    end
    if (!reset && tx_valid && tx_ready) begin
      if (exp_q.size() == 0)
        check("unexpected_byte", exp_q.size(), 1);
      else
        check("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
    end
    prev_stall <= !reset && tx_valid && !tx_ready;
    prev_data  <= tx_data;
  end

  initial begin
    int lat, len, busy;
    reset = 1'b1; timestamp = 24'h000000; enable = 1'b1; tx_ready = 1'b1;

    // 1: reset state and the frame of the zero timestamp
    @(posedge clk);
    @(negedge clk);
    check("rst_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_data", {24'd0, tx_data}, 32'd0);
    check("rst_busy", {31'd0, frame_busy}, 32'd0);
    check("rst_latched", {8'd0, ts_latched}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    step(2);
    reset = 1'b0;
    push_frame(24'h000000);
    wait_frame(40, lat, len);
    check("zero_len", len, 5);
    drain(40);
    check("zero_latched", {8'd0, ts_latched}, 32'd0);
    check("zero_idle", {29'd0, dbg_state}, {29'd0, ST_IDLE});

    // 2: data, checksum, latency and wrap
    timestamp = 24'h123456;
    push_frame(24'h123456);
    wait_frame(40, lat, len);
    check("latency", lat, 1 + 2 + STABLE);
    check("frame_len", len, 5);
    drain(40);
    timestamp = 24'hFFFFFF;
    push_frame(24'hFFFFFF);
    wait_frame(40, lat, len);
    check("ff_len", len, 5);
    drain(40);
    timestamp = 24'h000000;
    push_frame(24'h000000);
    wait_frame(40, lat, len);
    check("wrap_len", len, 5);
    drain(40);

    // 3: backpressure in B1
    timestamp = 24'hABCDEF;
    push_frame(24'hABCDEF);
    wait_state(ST_B1, "reach_b1");
    tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold", {24'd0, tx_data}, 32'h000000CD);
    end
    step(1);
    tx_ready = 1'b1;
    drain(40);

    // 4: glitching input yields one frame of the final value
    push_frame(24'h000010);
    for (int i = 0; i < 20; i++) begin
      timestamp = (i % 2 == 0) ? 24'h00000F : 24'h000010;
      step(1);
    end
    drain(60);
    check("glitch_latched", {8'd0, ts_latched}, 32'h000010);

    // 5: overrun under stall, frames for 1 and 3 back-to-back
    tx_ready = 1'b0;
    push_frame(24'h000001);
    push_frame(24'h000003);
    for (int v = 1; v <= 3; v++) begin
      timestamp = 24'(v);
      step(10);
    end
    check("overrun_set", {31'd0, overrun}, 32'd1);
    tx_ready = 1'b1;
    wait_frame(40, lat, len);
    check("b2b_len", len, 10);
    drain(40);
    check("overrun_sticky", {31'd0, overrun}, 32'd1);

    // 6: reset in B2 aborts the frame; a fresh frame follows
    timestamp = 24'h345678;
    push_frame(24'h345678);
    wait_state(ST_B2, "reach_b2");
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    exp_q.delete();
    push_frame(24'h345678);
    check("mid_rst_valid", {31'd0, tx_valid}, 32'd0);
    check("mid_rst_overrun", {31'd0, overrun}, 32'd0);
    check("mid_rst_latched", {8'd0, ts_latched}, 32'd0);
    wait_frame(40, lat, len);
    check("post_rst_lat", lat, STABLE + 3);
    check("post_rst_len", len, 5);
    drain(40);

    // ENABLE low: value latches but no frame
    enable = 1'b0;
    timestamp = 24'h00BEEF;
    busy = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      busy += int'(frame_busy);
    end
    check("en_busy", busy, 0);
    check("en_latched", {8'd0, ts_latched}, 32'h00BEEF);
    step(1);
    enable = 1'b1;
    step(10);
    check("en_no_frame", {31'd0, frame_busy}, 32'd0);
    check("final_queue", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
